alu_arbiter: RTL and testbench

Round-robin scheduler that shares one ALU datapath (control FSM plus operators) among `NUM_REQ` requesters. It accepts requests over a per-requester req/gnt handshake and latches the winner's opcode and operands. It then issues a single ALU start pulse, waits for the ALU done level (bounded by a watchdog), and returns the result to the originating requester. It sits between client blocks and the ALU top-level, and is the only driver of the ALU's start/opcode/operand inputs.

---
 rtl/alu_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin scheduler sharing one ALU among NUM_REQ requesters.
// Latches the winner's opcode/operands, pulses alu_start, waits for alu_done
// (bounded by a TIMEOUT watchdog) and returns the result to the originator.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   req/req_opcode/req_a/b  per-requester request level and packed payload
//   gnt                     one-hot pulse, operands taken
//   resp_valid/data/err     one-hot response pulse with result and error flag
//   busy                    high whenever not IDLE
//   alu_start/opcode/a/b    ALU command outputs (held until next latch)
//   alu_done/alu_result     ALU completion level and result
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [3*NUM_REQ-1:0]     req_opcode,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [2*WIDTH-1:0]       resp_data,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     alu_start,
  output logic [2:0]               alu_opcode,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic                     alu_done,
  input  logic [2*WIDTH-1:0]       alu_result
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam int unsigned RES_W = 2 * WIDTH;
  localparam logic [2:0]  OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [RES_W-1:0]     resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;
  logic                 busy_q, busy_d;
  logic                 alu_start_q, alu_start_d;
  logic [2:0]           alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;

  logic [2:0]           opc_arr [NUM_REQ];
  logic [WIDTH-1:0]     a_arr   [NUM_REQ];
  logic [WIDTH-1:0]     b_arr   [NUM_REQ];
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     cand;

  // Unpack the per-requester payload slices.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign opc_arr[g] = req_opcode[3*g +: 3];
    assign a_arr[g]   = req_a[WIDTH*g +: WIDTH];
    assign b_arr[g]   = req_b[WIDTH*g +: WIDTH];
  end

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + 32'(k)) % 32'(NUM_REQ));
      if (!sel_valid && req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    gnt_d        = '0;
    resp_valid_d = '0;
    alu_start_d  = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          idx_d        = sel_idx;
          alu_opcode_d = opc_arr[sel_idx];
          alu_a_d      = a_arr[sel_idx];
          alu_b_d      = b_arr[sel_idx];
          // gnt/alu_start are registered so they appear during ISSUE.
          gnt_d        = NUM_REQ'(1) << sel_idx;
          alu_start_d  = (opc_arr[sel_idx] != OP_ILLEGAL);
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (alu_opcode_q == OP_ILLEGAL) begin
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
          resp_valid_d = NUM_REQ'(1) << idx_q;
          state_d      = ST_RESP;
        end else begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // First WAIT cycle ignores done: it is left over from the last op.
        if ((timer_q != '0) && alu_done) begin
          resp_err_d   = 1'b0;
          resp_data_d  = alu_result;
          resp_valid_d = NUM_REQ'(1) << idx_q;
          state_d      = ST_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
          resp_valid_d = NUM_REQ'(1) << idx_q;
          state_d      = ST_RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_RESP: begin
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      alu_start_q  <= 1'b0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      alu_start_q  <= alu_start_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
    end
  end

  assign gnt        = gnt_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign alu_start  = alu_start_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard testbench for alu_arbiter: directed requests with hand-computed
// results, a behavioural ALU with programmable latency, and a monitor that
// checks grants and responses against queued expectations.
module tb_alu_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned RES_W   = 2 * WIDTH;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [3*NUM_REQ-1:0]     req_opcode = '0;
  logic [WIDTH*NUM_REQ-1:0] req_a = '0;
  logic [WIDTH*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [RES_W-1:0]         resp_data;
  logic                     resp_err;
  logic                     busy;
  logic                     alu_start;
  logic [2:0]               alu_opcode;
  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic                     alu_done = 1'b0;
  logic [RES_W-1:0]         alu_result = '0;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .gnt(gnt), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a),
    .alu_b(alu_b), .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: done stays high one extra cycle after start (stale),
  // then drops, then rises alu_lat cycles after the start cycle.
  int          alu_lat = 4;
  bit          alu_hang = 1'b0;
  int          m_cnt = 0;
  bit          m_active = 1'b0;
  logic [RES_W-1:0] m_res = '0;
  always @(posedge clk) begin
    if (alu_start) begin
      m_active <= 1'b1;
      m_cnt    <= 1;
      case (alu_opcode)
        3'b000:  m_res <= RES_W'(alu_a) + RES_W'(alu_b);
        3'b010:  m_res <= RES_W'(alu_a) * RES_W'(alu_b);
        default: m_res <= '0;
      endcase
    end else if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 1) alu_done <= 1'b0;
      if (m_cnt == alu_lat - 1 && !alu_hang) begin
        alu_done   <= 1'b1;
        alu_result <= m_res;
        m_active   <= 1'b0;
      end
    end
  end

  typedef struct {
    int               idx;
    logic [2:0]       opc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    bit               has_resp;
    logic [RES_W-1:0] data;
    logic             err;
    int               lat;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic int oh2idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: pops expectations whenever the DUT presents gnt or resp_valid.
  bit prev_gnt = 1'b0;
  bit prev_resp = 1'b0;
  int gnt_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (gnt != '0) begin
        chk("gnt_onehot", longint'($onehot(gnt)), 1);
        chk("gnt_pulse", longint'(prev_gnt), 0);
        gnt_cyc = cyc;
        if (gq.size() == 0) fail_now("gnt_unexpected");
        else begin
          e = gq.pop_front();
          chk("gnt_idx", oh2idx(gnt), e.idx);
          chk("alu_start", longint'(alu_start), longint'(e.start));
          chk("alu_opcode", longint'(alu_opcode), longint'(e.opc));
          chk("alu_a", longint'(alu_a), longint'(e.a));
          chk("alu_b", longint'(alu_b), longint'(e.b));
          if (e.has_resp) rq.push_back(e);
        end
      end else if (alu_start) begin
        fail_now("alu_start_without_gnt");
      end
      if (resp_valid != '0) begin
        chk("resp_onehot", longint'($onehot(resp_valid)), 1);
        chk("resp_pulse", longint'(prev_resp), 0);
        if (rq.size() == 0) fail_now("resp_unexpected");
        else begin
          e = rq.pop_front();
          chk("resp_idx", oh2idx(resp_valid), e.idx);
          chk("resp_data", longint'(resp_data), longint'(e.data));
          chk("resp_err", longint'(resp_err), longint'(e.err));
          chk("resp_latency", cyc - gnt_cyc, e.lat);
        end
      end
    end
    prev_gnt  = (gnt != '0);
    prev_resp = (resp_valid != '0);
  end

  task automatic expect_op(input int idx, input logic [2:0] opc,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic start, input bit has_resp,
                           input logic [RES_W-1:0] data, input logic err,
                           input int lat);
    exp_t e;
    e.idx = idx; e.opc = opc; e.a = a; e.b = b; e.start = start;
    e.has_resp = has_resp; e.data = data; e.err = err; e.lat = lat;
    gq.push_back(e);
  endtask

  task automatic raise(input int idx, input logic [2:0] opc,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_opcode[3*idx +: 3]   = opc;
    req_a[WIDTH*idx +: WIDTH] = a;
    req_b[WIDTH*idx +: WIDTH] = b;
    req[idx] = 1'b1;
  endtask

  // Wait for a grant, then drop the granted requester's req.
  task automatic serve(output int g);
    g = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g = oh2idx(gnt);
        req[g] = 1'b0;
        break;
      end
    end
    if (g < 0) fail_now("gnt_timeout");
  endtask

  task automatic wait_resp();
    bit seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 50; i++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("resp_wait_timeout");
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 4 * TIMEOUT + 100; i++) begin
      @(negedge clk);
      if (gq.size() == 0 && rq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      fail_now("drain_timeout");
      gq.delete();
      rq.delete();
    end
  endtask

  task automatic run_one(input int idx, input logic [2:0] opc,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic start, input logic [RES_W-1:0] data,
                         input logic err, input int lat);
    int g;
    expect_op(idx, opc, a, b, start, 1'b1, data, err, lat);
    raise(idx, opc, a, b);
    serve(g);
    drain();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, longint'(gnt), 0);
    chk({tag, "_resp_valid"}, longint'(resp_valid), 0);
    chk({tag, "_resp_data"}, longint'(resp_data), 0);
    chk({tag, "_resp_err"}, longint'(resp_err), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_alu_start"}, longint'(alu_start), 0);
    chk({tag, "_alu_opcode"}, longint'(alu_opcode), 0);
    chk({tag, "_alu_a"}, longint'(alu_a), 0);
    chk({tag, "_alu_b"}, longint'(alu_b), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int g;

    do_reset("rst0");

    // Single add, ALU done 4 cycles after start.
    alu_lat = 4;
    run_one(0, 3'b000, 8'd5, 8'd3, 1'b1, 16'd8, 1'b0, 5);

    // Multiply, then an add that must not use the stale done.
    alu_lat = 3;
    run_one(1, 3'b010, 8'd200, 8'd3, 1'b1, 16'd600, 1'b0, 4);
    alu_lat = 5;
    run_one(2, 3'b000, 8'd7, 8'd9, 1'b1, 16'd16, 1'b0, 6);

    // Reset during WAIT: request dropped, pointer back to 0.
    alu_hang = 1'b1;
    expect_op(3, 3'b000, 8'd1, 8'd2, 1'b1, 1'b0, 16'd0, 1'b0, 0);
    raise(3, 3'b000, 8'd1, 8'd2);
    serve(g);
    repeat (3) @(negedge clk);
    chk("busy_in_wait", longint'(busy), 1);
    do_reset("rst_wait");
    alu_hang = 1'b0;
    alu_lat  = 3;
    repeat (6) @(negedge clk);
    expect_op(0, 3'b000, 8'd20, 8'd22, 1'b1, 1'b1, 16'd42, 1'b0, 4);
    expect_op(3, 3'b000, 8'd255, 8'd1, 1'b1, 1'b1, 16'd256, 1'b0, 4);
    raise(0, 3'b000, 8'd20, 8'd22);
    raise(3, 3'b000, 8'd255, 8'd1);
    serve(g);
    serve(g);
    drain();

    // Timeout: done never rises.
    alu_hang = 1'b1;
    run_one(0, 3'b000, 8'd1, 8'd1, 1'b1, 16'd0, 1'b1, TIMEOUT + 1);

    // Illegal opcode: no ALU start, error response one cycle after grant.
    run_one(3, 3'b111, 8'd9, 8'd9, 1'b0, 16'd0, 1'b1, 1);

    // Done arrives in the last WAIT cycle: done wins over timeout.
    alu_hang = 1'b0;
    alu_lat  = TIMEOUT;
    run_one(1, 3'b000, 8'd100, 8'd50, 1'b1, 16'd150, 1'b0, TIMEOUT + 1);

    // Round-robin fairness with all requesters held.
    do_reset("rst_rr");
    alu_lat = 3;
    expect_op(0, 3'b000, 8'd1,  8'd0, 1'b1, 1'b1, 16'd1,  1'b0, 4);
    expect_op(1, 3'b000, 8'd11, 8'd1, 1'b1, 1'b1, 16'd12, 1'b0, 4);
    expect_op(2, 3'b000, 8'd21, 8'd2, 1'b1, 1'b1, 16'd23, 1'b0, 4);
    expect_op(3, 3'b000, 8'd31, 8'd3, 1'b1, 1'b1, 16'd34, 1'b0, 4);
    expect_op(0, 3'b000, 8'd1,  8'd0, 1'b1, 1'b1, 16'd1,  1'b0, 4);
    expect_op(1, 3'b000, 8'd11, 8'd1, 1'b1, 1'b1, 16'd12, 1'b0, 4);
    for (int i = 0; i < NUM_REQ; i++)
      raise(i, 3'b000, WIDTH'(10 * i + 1), WIDTH'(i));
    for (int n = 0; n < 6; n++) begin
      serve(g);
      if (n == 5) req = '0;
      wait_resp();
      if (n < 4 && g >= 0) req[g] = 1'b1;
    end
    drain();

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
